if_stage: RTL and testbench
===========================

IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the PC value loaded on reset.
REQ-002 SHALL have parameter NOP_INST, default 32'h0000_0013 (ADDI x0,x0,0), meaning the bubble instruction driven on pipe_data.
REQ-003 SHALL have ports: clk  in  1  sole clock, rising edge.
REQ-004 SHALL have ports: reset_n  in  1  synchronous, active-low reset.
REQ-005 SHALL have ports: stall  in  1  decode cannot accept; hold pipe outputs.
REQ-006 SHALL have ports: control_j  in  1  redirect request from decode.
REQ-007 SHALL have ports: pc_j  in  32  redirect target.
REQ-008 SHALL have ports: imem_req  out  1  instruction-memory read request.
REQ-009 SHALL have ports: imem_addr  out  32  fetch address, always equal to the PC register.
REQ-010 SHALL have ports: imem_ready  in  1  imem_rdata valid this cycle.
REQ-011 SHALL have ports: imem_rdata  in  32  fetched instruction.
REQ-012 SHALL have ports: pipe_pc  out  32  PC of the instruction on pipe_data.
REQ-013 SHALL have ports: pipe_data  out  32  instruction to decode.
REQ-014 SHALL have ports: pipe_valid  out  1  pipe_data holds a real instruction.

Function
REQ-015 SHALL implement an FSM with states IDLE (after reset, imem_req=0), FETCH (imem_req=1) and HOLD (imem_req=0, one instruction buffered); IDLE SHALL go to FETCH unconditionally after one cycle.
REQ-016 In FETCH, when imem_ready=1, stall=0 and control_j=0, the block SHALL register pipe_data<=imem_rdata, pipe_pc<=PC and pipe_valid<=1, and set PC<=PC+4, giving one-cycle latency from ready to pipe outputs.
REQ-017 In FETCH, when imem_ready=0 and stall=0, the block SHALL register pipe_data<=NOP_INST and pipe_valid<=0, and hold PC.
REQ-018 In FETCH, when imem_ready=1 and stall=1, the block SHALL capture imem_rdata and PC into a one-entry buffer, set PC<=PC+4, enter HOLD, and leave the pipe outputs unchanged.
REQ-019 In FETCH, when imem_ready=0 and stall=1, the block SHALL change neither PC nor the pipe outputs.
REQ-020 In HOLD, when stall=0, the block SHALL load the buffer into pipe_data/pipe_pc with pipe_valid=1 and return to FETCH.
REQ-021 In HOLD, while stall=1, the block SHALL hold all outputs.
REQ-022 control_j=1 SHALL take priority over stall and imem_ready in every non-reset state: PC<=pc_j with bits [1:0] forced to 00, pipe_data<=NOP_INST, pipe_pc<=0, pipe_valid<=0, buffer discarded, next state FETCH; any same-cycle imem response SHALL be dropped.
REQ-023 PC+4 SHALL wrap modulo 2^32 (32'hFFFF_FFFC becomes 32'h0000_0000).
REQ-024 The pipe outputs SHALL be registers only, with no combinational path from imem_rdata to pipe_data.

Reset
REQ-025 While reset_n=0 at a clk rising edge, the block SHALL set: PC=RESET_PC, state=IDLE, pipe_data=NOP_INST, pipe_pc=0, pipe_valid=0, buffer cleared, and both counters (if present) =0.
REQ-026 Reset SHALL override control_j and stall.
REQ-027 Reset asserted mid-HOLD SHALL discard the buffered instruction.

Configuration
REQ-028 With macro IF_PERF_CNT_EN defined, the block SHALL add output fetch_cnt[31:0], incremented (wrapping) on each cycle that pipe_valid is loaded with 1.
REQ-029 With macro IF_PERF_CNT_EN defined, the block SHALL add output flush_cnt[15:0], incremented (wrapping) on each cycle control_j=1 outside reset.
REQ-030 Without IF_PERF_CNT_EN, these ports and counters SHALL be absent, with no other behaviour change.

Verification
REQ-031 Reset release with imem_ready=1 permanently and rdata=PC-derived: the first pipe_valid SHALL occur 2 cycles after release with pipe_pc=0, then 4, 8, ... one per cycle.
REQ-032 Assert stall for 3 cycles while imem_ready=1 at PC=8: pipe holds PC 4; the instruction at 8 SHALL be buffered and appear on the first cycle after stall drops; no instruction SHALL be lost or duplicated.
REQ-033 control_j=1 with pc_j=32'h0000_0102 during stall in HOLD: the next cycle SHALL show pipe_valid=0, pipe_data=32'h0000_0013, imem_addr=32'h0000_0100, with the buffered instruction dropped.
REQ-034 Start at PC=32'hFFFF_FFFC with imem_ready=1: the next imem_addr SHALL be 32'h0000_0000.
REQ-035 imem_ready low for 2 cycles: 2 bubbles SHALL appear (pipe_valid=0, NOP) and PC SHALL be unchanged.
REQ-036 With IF_PERF_CNT_EN defined, 10 delivered instructions and 2 redirects SHALL give fetch_cnt=10 and flush_cnt=2, and a mid-run reset SHALL zero both.

Source files
------------

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC register, imem request FSM (IDLE/FETCH/HOLD), a one-entry
// skid buffer for stalls, and registered pipe outputs. Define IF_PERF_CNT_EN for fetch/flush counters.
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        stall,
    input  logic        control_j,
    input  logic [31:0] pc_j,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] pipe_pc,
    output logic [31:0] pipe_data,
    output logic        pipe_valid,
`ifdef IF_PERF_CNT_EN
    output logic [31:0] fetch_cnt,
    output logic [15:0] flush_cnt,
`endif
    output logic [1:0]  state_dbg
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_HOLD  = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] pipe_data_q, pipe_data_d;
    logic [31:0] pipe_pc_q, pipe_pc_d;
    logic        pipe_valid_q, pipe_valid_d;
    logic [31:0] buf_data_q, buf_data_d;
    logic [31:0] buf_pc_q, buf_pc_d;
    logic        deliver;
    logic [31:0] pc_inc;

    // Natural 32-bit overflow gives the required wrap from FFFF_FFFC to 0.
    assign pc_inc = pc_q + 32'd4;

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        pipe_data_d  = pipe_data_q;
        pipe_pc_d    = pipe_pc_q;
        pipe_valid_d = pipe_valid_q;
        buf_data_d   = buf_data_q;
        buf_pc_d     = buf_pc_q;
        deliver      = 1'b0;

        if (control_j) begin
            // Redirect wins over stall and any same-cycle imem response.
            state_d      = S_FETCH;
            pc_d         = {pc_j[31:2], 2'b00};
            pipe_data_d  = NOP_INST;
            pipe_pc_d    = 32'd0;
            pipe_valid_d = 1'b0;
            buf_data_d   = NOP_INST;
            buf_pc_d     = 32'd0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    state_d = S_FETCH;
                end
                S_FETCH: begin
                    if (!stall) begin
                        if (imem_ready) begin
                            pipe_data_d  = imem_rdata;
                            pipe_pc_d    = pc_q;
                            pipe_valid_d = 1'b1;
                            pc_d         = pc_inc;
                            deliver      = 1'b1;
                        end else begin
                            pipe_data_d  = NOP_INST;
                            pipe_valid_d = 1'b0;
                        end
                    end else if (imem_ready) begin
                        // Decode is blocked: park the response so it is not lost.
                        buf_data_d = imem_rdata;
                        buf_pc_d   = pc_q;
                        pc_d       = pc_inc;
                        state_d    = S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (!stall) begin
                        pipe_data_d  = buf_data_q;
                        pipe_pc_d    = buf_pc_q;
                        pipe_valid_d = 1'b1;
                        deliver      = 1'b1;
                        state_d      = S_FETCH;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            pc_q         <= RESET_PC;
            pipe_data_q  <= NOP_INST;
            pipe_pc_q    <= 32'd0;
            pipe_valid_q <= 1'b0;
            buf_data_q   <= NOP_INST;
            buf_pc_q     <= 32'd0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            pipe_data_q  <= pipe_data_d;
            pipe_pc_q    <= pipe_pc_d;
            pipe_valid_q <= pipe_valid_d;
            buf_data_q   <= buf_data_d;
            buf_pc_q     <= buf_pc_d;
        end
    end

`ifdef IF_PERF_CNT_EN
    logic [31:0] fetch_cnt_q, fetch_cnt_d;
    logic [15:0] flush_cnt_q, flush_cnt_d;

    always_comb begin
        fetch_cnt_d = deliver   ? fetch_cnt_q + 32'd1 : fetch_cnt_q;
        flush_cnt_d = control_j ? flush_cnt_q + 16'd1 : flush_cnt_q;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            fetch_cnt_q <= 32'd0;
            flush_cnt_q <= 16'd0;
        end else begin
            fetch_cnt_q <= fetch_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign fetch_cnt = fetch_cnt_q;
    assign flush_cnt = flush_cnt_q;
`endif

    assign imem_req   = (state_q == S_FETCH);
    assign imem_addr  = pc_q;
    assign pipe_pc    = pipe_pc_q;
    assign pipe_data  = pipe_data_q;
    assign pipe_valid = pipe_valid_q;
    assign state_dbg  = state_q;

endmodule

// File: tb/tb_if_stage.sv
// Directed table-driven bench for if_stage: each row applies inputs for one clock edge
// and compares the registered outputs just after that edge.
module tb_if_stage;

    localparam logic [31:0] NOP  = 32'h0000_0013;
    localparam logic [31:0] JUNK = 32'hDEAD_BEEF;

    logic        clk;
    logic        reset_n;
    logic        stall;
    logic        control_j;
    logic [31:0] pc_j;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic [31:0] pipe_pc;
    logic [31:0] pipe_data;
    logic        pipe_valid;
    logic [1:0]  state_dbg;
`ifdef IF_PERF_CNT_EN
    logic [31:0] fetch_cnt;
    logic [15:0] flush_cnt;
`endif

    int checks   = 0;
    int failures = 0;

    if_stage dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .stall      (stall),
        .control_j  (control_j),
        .pc_j       (pc_j),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ready (imem_ready),
        .imem_rdata (imem_rdata),
        .pipe_pc    (pipe_pc),
        .pipe_data  (pipe_data),
        .pipe_valid (pipe_valid),
`ifdef IF_PERF_CNT_EN
        .fetch_cnt  (fetch_cnt),
        .flush_cnt  (flush_cnt),
`endif
        .state_dbg  (state_dbg)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst_n;
        logic        stall;
        logic        j;
        logic [31:0] pcj;
        logic        rdy;
        logic [31:0] rdata;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_valid;
        logic        chk_ppc;
        logic [31:0] e_ppc;
        logic [31:0] e_data;
    } vec_t;

    vec_t vec_q[$];

    // Instruction word the fake memory returns for a given address.
    function automatic logic [31:0] inst(input logic [31:0] a);
        return 32'hA500_0000 ^ a;
    endfunction

    task automatic add(input logic rst_n, input logic st, input logic j, input logic [31:0] pcj,
                       input logic rdy, input logic [31:0] rdata,
                       input logic e_req, input logic [31:0] e_addr, input logic e_valid,
                       input logic chk_ppc, input logic [31:0] e_ppc, input logic [31:0] e_data);
        vec_t v;
        v.rst_n = rst_n; v.stall = st; v.j = j; v.pcj = pcj; v.rdy = rdy; v.rdata = rdata;
        v.e_req = e_req; v.e_addr = e_addr; v.e_valid = e_valid;
        v.chk_ppc = chk_ppc; v.e_ppc = e_ppc; v.e_data = e_data;
        vec_q.push_back(v);
    endtask

    task automatic chk(input string name, input int row, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s row=%0d actual=%h expected=%h", name, row, act, exp);
        end
    endtask

    // driver: apply inputs on the falling edge, let one rising edge pass, sample 1 time unit later
    task automatic drive(input logic rst_n, input logic st, input logic j, input logic [31:0] pcj,
                         input logic rdy, input logic [31:0] rdata);
        @(negedge clk);
        reset_n    = rst_n;
        stall      = st;
        control_j  = j;
        pc_j       = pcj;
        imem_ready = rdy;
        imem_rdata = rdata;
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset_n = 1'b0; stall = 1'b0; control_j = 1'b0; pc_j = 32'd0;
        imem_ready = 1'b0; imem_rdata = 32'd0;

        //   rst st j  pc_j          rdy rdata               req addr          vld cp ppc           data
        add(0, 0, 0, 32'h0,         0, JUNK,                0, 32'h0,         0, 1, 32'h0,         NOP);
        add(0, 1, 1, 32'h80,        1, JUNK,                0, 32'h0,         0, 1, 32'h0,         NOP);
        add(1, 0, 0, 32'h0,         1, inst(32'h0),         1, 32'h0,         0, 1, 32'h0,         NOP);
        add(1, 0, 0, 32'h0,         1, inst(32'h0),         1, 32'h4,         1, 1, 32'h0,         inst(32'h0));
        add(1, 0, 0, 32'h0,         1, inst(32'h4),         1, 32'h8,         1, 1, 32'h4,         inst(32'h4));
        add(1, 1, 0, 32'h0,         1, inst(32'h8),         0, 32'hC,         1, 1, 32'h4,         inst(32'h4));
        add(1, 1, 0, 32'h0,         1, JUNK,                0, 32'hC,         1, 1, 32'h4,         inst(32'h4));
        add(1, 1, 0, 32'h0,         1, JUNK,                0, 32'hC,         1, 1, 32'h4,         inst(32'h4));
        add(1, 0, 0, 32'h0,         1, JUNK,                1, 32'hC,         1, 1, 32'h8,         inst(32'h8));
        add(1, 0, 0, 32'h0,         1, inst(32'hC),         1, 32'h10,        1, 1, 32'hC,         inst(32'hC));
        add(1, 0, 0, 32'h0,         0, JUNK,                1, 32'h10,        0, 0, 32'h0,         NOP);
        add(1, 0, 0, 32'h0,         0, JUNK,                1, 32'h10,        0, 0, 32'h0,         NOP);
        add(1, 0, 0, 32'h0,         1, inst(32'h10),        1, 32'h14,        1, 1, 32'h10,        inst(32'h10));
        add(1, 1, 0, 32'h0,         0, JUNK,                1, 32'h14,        1, 1, 32'h10,        inst(32'h10));
        add(1, 1, 0, 32'h0,         1, inst(32'h14),        0, 32'h18,        1, 1, 32'h10,        inst(32'h10));
        add(1, 1, 1, 32'h102,       1, JUNK,                1, 32'h100,       0, 1, 32'h0,         NOP);
        add(1, 0, 0, 32'h0,         1, inst(32'h100),       1, 32'h104,       1, 1, 32'h100,       inst(32'h100));
        add(1, 0, 1, 32'hFFFF_FFFF, 1, inst(32'h104),       1, 32'hFFFF_FFFC, 0, 1, 32'h0,         NOP);
        add(1, 0, 0, 32'h0,         1, inst(32'hFFFF_FFFC), 1, 32'h0,         1, 1, 32'hFFFF_FFFC, inst(32'hFFFF_FFFC));
        add(1, 0, 0, 32'h0,         1, inst(32'h0),         1, 32'h4,         1, 1, 32'h0,         inst(32'h0));
        add(1, 0, 1, 32'h8,         0, JUNK,                1, 32'h8,         0, 1, 32'h0,         NOP);
        add(1, 1, 0, 32'h0,         1, inst(32'h8),         0, 32'hC,         0, 1, 32'h0,         NOP);
        add(0, 1, 1, 32'h40,        1, JUNK,                0, 32'h0,         0, 1, 32'h0,         NOP);
        add(1, 0, 0, 32'h0,         0, JUNK,                1, 32'h0,         0, 0, 32'h0,         NOP);
        add(1, 0, 0, 32'h0,         0, JUNK,                1, 32'h0,         0, 0, 32'h0,         NOP);
        add(1, 0, 0, 32'h0,         1, inst(32'h0),         1, 32'h4,         1, 1, 32'h0,         inst(32'h0));

        foreach (vec_q[i]) begin
            drive(vec_q[i].rst_n, vec_q[i].stall, vec_q[i].j, vec_q[i].pcj, vec_q[i].rdy, vec_q[i].rdata);
            chk("imem_req",   i, {31'd0, imem_req},   {31'd0, vec_q[i].e_req});
            chk("imem_addr",  i, imem_addr,           vec_q[i].e_addr);
            chk("pipe_valid", i, {31'd0, pipe_valid}, {31'd0, vec_q[i].e_valid});
            chk("pipe_data",  i, pipe_data,           vec_q[i].e_data);
            if (vec_q[i].chk_ppc)
                chk("pipe_pc", i, pipe_pc, vec_q[i].e_ppc);
        end

`ifdef IF_PERF_CNT_EN
        // 10 deliveries and 2 redirects from a clean reset, then a mid-run reset
        drive(0, 0, 0, 32'h0, 0, JUNK);
        chk("fetch_cnt_rst", 100, fetch_cnt, 32'd0);
        chk("flush_cnt_rst", 100, {16'd0, flush_cnt}, 32'd0);
        drive(1, 0, 0, 32'h0, 1, JUNK);
        for (int k = 0; k < 10; k++)
            drive(1, 0, 0, 32'h0, 1, inst(32'(k * 4)));
        drive(1, 0, 1, 32'h200, 1, JUNK);
        drive(1, 1, 1, 32'h300, 0, JUNK);
        chk("fetch_cnt", 101, fetch_cnt, 32'd10);
        chk("flush_cnt", 101, {16'd0, flush_cnt}, 32'd2);
        drive(0, 0, 1, 32'h0, 1, JUNK);
        chk("fetch_cnt_mid_rst", 102, fetch_cnt, 32'd0);
        chk("flush_cnt_mid_rst", 102, {16'd0, flush_cnt}, 32'd0);
`endif

        // final report
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
